// File: rtl/lsu_pkg.sv
// Shared op codes, FSM states and op classifiers for the
// load/store memory port.
package lsu_pkg;

  localparam logic [2:0] LSU_LW  = 3'd0;
  localparam logic [2:0] LSU_LH  = 3'd1;
  localparam logic [2:0] LSU_LHU = 3'd2;
  localparam logic [2:0] LSU_LB  = 3'd3;
  localparam logic [2:0] LSU_LBU = 3'd4;
  localparam logic [2:0] LSU_SW  = 3'd5;
  localparam logic [2:0] LSU_SH  = 3'd6;
  localparam logic [2:0] LSU_SB  = 3'd7;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_WAIT,
    LSU_DONE
  } lsu_state_e;

  function automatic logic is_store(
    input logic [2:0] op
  );
    return op inside {LSU_SW, LSU_SH, LSU_SB};
  endfunction

  function automatic logic is_half(
    input logic [2:0] op
  );
    return op inside {LSU_LH, LSU_LHU, LSU_SH};
  endfunction

  function automatic logic is_byte(
    input logic [2:0] op
  );
    return op inside {LSU_LB, LSU_LBU, LSU_SB};
  endfunction

  function automatic logic is_misaligned(
    input logic [2:0] op,
    input logic [1:0] a
  );
    logic r;
    r = 1'b0;
    unique case (1'b1)
      is_byte(op): r = 1'b0;
      is_half(op): r = a[0];
      default:     r = (a != 2'b00);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a memory word and
// extends it; stores yield zero.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (off_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    result_o = '0;
    unique case (op_i)
      LSU_LW:  result_o = word_i;
      LSU_LH:  result_o = {{16{half_sel[15]}}, half_sel};
      LSU_LHU: result_o = {16'h0, half_sel};
      LSU_LB:  result_o = {{24{byte_sel[7]}}, byte_sel};
      LSU_LBU: result_o = {24'h0, byte_sel};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// MEM-stage initiator for a word-wide, byte-enabled data memory:
// alignment check, store lane encoding, load extension, timeout.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err,
  output logic [31:0] exc_pc,
  output logic [31:0] exc_badvaddr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e state_q, state_d;

  logic [2:0]    op_q;
  logic [1:0]    off_q;
  logic [CW-1:0] cnt_q;
  logic          adel_q, ades_q, berr_q;
  logic          we_q;
  logic [3:0]    be_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [31:0]   pc_q, badva_q;

  logic        misal;
  logic        tmo_hit;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] load_res;

  assign misal   = is_misaligned(req_op, req_addr[1:0]);
  assign tmo_hit = (cnt_q == CNT_LAST);

  lsu_load_align u_align (
    .op_i     (op_q),
    .off_i    (off_q),
    .word_i   (mem_rdata),
    .result_o (load_res)
  );

  // Little-endian lane placement; the data is replicated so the
  // memory only has to honour byte enables.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = '0;
    unique case (1'b1)
      is_store(req_op) && is_byte(req_op): begin
        be_d    = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      is_store(req_op) && is_half(req_op): begin
        be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{req_wdata[15:0]}};
      end
      req_op == LSU_SW: begin
        wdata_d = req_wdata;
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= LSU_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LSU_IDLE:
        if (req_valid)
          state_d = misal ? LSU_DONE : LSU_WAIT;
      LSU_WAIT:
        if (mem_ack || tmo_hit)
          state_d = LSU_DONE;
      LSU_DONE:
        state_d = LSU_IDLE;
      default:
        state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != LSU_IDLE);
    done     = (state_q == LSU_DONE);
    mem_req  = (state_q == LSU_WAIT);
    exc_adel = done && adel_q;
    exc_ades = done && ades_q;
    bus_err  = done && berr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      adel_q  <= 1'b0;
      ades_q  <= 1'b0;
      berr_q  <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      pc_q    <= '0;
      badva_q <= '0;
    end else begin
      unique case (state_q)
        LSU_IDLE: begin
          cnt_q <= '0;
          if (req_valid) begin
            op_q    <= req_op;
            off_q   <= req_addr[1:0];
            pc_q    <= req_pc;
            badva_q <= req_addr;
            rdata_q <= '0;
            berr_q  <= 1'b0;
            adel_q  <= misal && !is_store(req_op);
            ades_q  <= misal && is_store(req_op);
            if (!misal) begin
              we_q    <= is_store(req_op);
              be_q    <= be_d;
              addr_q  <= {req_addr[31:2], 2'b00};
              wdata_q <= wdata_d;
            end
          end
        end
        LSU_WAIT: begin
          // Ack beats a timeout landing on the same cycle.
          if (mem_ack)
            rdata_q <= load_res;
          else if (tmo_hit)
            berr_q <= 1'b1;
          else
            cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign rdata        = rdata_q;
  assign exc_pc       = pc_q;
  assign exc_badvaddr = badva_q;
  assign mem_we       = we_q;
  assign mem_be       = be_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: vector table plus
// timeout, late-ack and mid-transaction reset sequences.
module tb_lsu_mem_port;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        busy, done, exc_adel, exc_ades, bus_err;
  logic [31:0] rdata, exc_pc, exc_badvaddr;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_mem_port #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_pc       (req_pc),
    .busy         (busy),
    .done         (done),
    .rdata        (rdata),
    .exc_adel     (exc_adel),
    .exc_ades     (exc_ades),
    .bus_err      (bus_err),
    .exc_pc       (exc_pc),
    .exc_badvaddr (exc_badvaddr),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    int          dly;
    logic [31:0] erd;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic        adel;
    logic        ades;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic start(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [31:0] pc);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = wd;
    req_pc    = pc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_vec(input string nm, input vec_t v,
                        input logic [31:0] pc);
    logic st;
    st = (v.op >= LSU_SW);
    start(v.op, v.addr, v.wdata, pc);
    if (v.adel || v.ades) begin
      chk({nm, "_busy"}, busy, 1);
      chk({nm, "_done"}, done, 1);
      chk({nm, "_req"}, mem_req, 0);
      chk({nm, "_adel"}, exc_adel, v.adel);
      chk({nm, "_ades"}, exc_ades, v.ades);
      chk({nm, "_berr"}, bus_err, 0);
      chk({nm, "_bva"}, exc_badvaddr, v.addr);
      chk({nm, "_pc"}, exc_pc, pc);
      chk({nm, "_rd"}, rdata, 0);
    end else begin
      chk({nm, "_req"}, mem_req, 1);
      chk({nm, "_done0"}, done, 0);
      chk({nm, "_we"}, mem_we, st);
      chk({nm, "_be"}, mem_be, v.ebe);
      chk({nm, "_addr"}, mem_addr,
          {v.addr[31:2], 2'b00});
      if (st) chk({nm, "_wd"}, mem_wdata, v.ewd);
      for (int w = 0; w < v.dly; w++) begin
        @(negedge clk);
        chk({nm, "_hold"}, mem_req, 1);
        chk({nm, "_be_hold"}, mem_be, v.ebe);
        chk({nm, "_done_w"}, done, 0);
      end
      mem_ack   = 1'b1;
      mem_rdata = v.mrd;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'h0BAD_F00D;
      chk({nm, "_done"}, done, 1);
      chk({nm, "_busy"}, busy, 1);
      chk({nm, "_req_off"}, mem_req, 0);
      chk({nm, "_rd"}, rdata, v.erd);
      chk({nm, "_berr"}, bus_err, 0);
      chk({nm, "_exc"}, {exc_adel, exc_ades}, 0);
      chk({nm, "_pc"}, exc_pc, pc);
      chk({nm, "_bva"}, exc_badvaddr, v.addr);
    end
    @(negedge clk);
    chk({nm, "_idle_busy"}, busy, 0);
    chk({nm, "_idle_done"}, done, 0);
  endtask

  function automatic vec_t mk(
    input logic [2:0] op, input logic [31:0] a,
    input logic [31:0] wd, input logic [31:0] mrd,
    input int dly, input logic [31:0] erd,
    input logic [3:0] ebe, input logic [31:0] ewd,
    input logic adel, input logic ades);
    vec_t v;
    v.op = op; v.addr = a; v.wdata = wd; v.mrd = mrd;
    v.dly = dly; v.erd = erd; v.ebe = ebe; v.ewd = ewd;
    v.adel = adel; v.ades = ades;
    return v;
  endfunction

  initial begin
    vt[0]  = mk(LSU_SB, 32'h13, 32'hA5, 32'h0, 0,
                32'h0, 4'b1000, 32'hA5A5A5A5, 0, 0);
    vt[1]  = mk(LSU_LB, 32'h2, 32'h0, 32'h12F03456, 0,
                32'hFFFFFFF0, 4'b1111, 32'h0, 0, 0);
    vt[2]  = mk(LSU_LBU, 32'h2, 32'h0, 32'h12F03456, 0,
                32'h000000F0, 4'b1111, 32'h0, 0, 0);
    vt[3]  = mk(LSU_LH, 32'h6, 32'h0, 32'h8001FFFF, 0,
                32'hFFFF8001, 4'b1111, 32'h0, 0, 0);
    vt[4]  = mk(LSU_LHU, 32'h6, 32'h0, 32'h8001FFFF, 0,
                32'h00008001, 4'b1111, 32'h0, 0, 0);
    vt[5]  = mk(LSU_LW, 32'h100, 32'h0, 32'hDEADBEEF, 2,
                32'hDEADBEEF, 4'b1111, 32'h0, 0, 0);
    vt[6]  = mk(LSU_SH, 32'h22, 32'h1234ABCD, 32'h0, 0,
                32'h0, 4'b1100, 32'hABCDABCD, 0, 0);
    vt[7]  = mk(LSU_SW, 32'h40, 32'hCAFEF00D, 32'h0, 1,
                32'h0, 4'b1111, 32'hCAFEF00D, 0, 0);
    vt[8]  = mk(LSU_LB, 32'h1, 32'h0, 32'h00007F00, 0,
                32'h0000007F, 4'b1111, 32'h0, 0, 0);
    vt[9]  = mk(LSU_SB, 32'h1, 32'h3C, 32'h0, 0,
                32'h0, 4'b0010, 32'h3C3C3C3C, 0, 0);
    vt[10] = mk(LSU_LW, 32'h102, 32'h0, 32'h0, 0,
                32'h0, 4'b0000, 32'h0, 1, 0);
    vt[11] = mk(LSU_SH, 32'h101, 32'h0, 32'h0, 0,
                32'h0, 4'b0000, 32'h0, 0, 1);
    vt[12] = mk(LSU_LB, 32'h3, 32'h0, 32'h80000000, 0,
                32'hFFFFFF80, 4'b1111, 32'h0, 0, 0);
    vt[13] = mk(LSU_SH, 32'h50, 32'h0000BEEF, 32'h0, 0,
                32'h0, 4'b0011, 32'hBEEFBEEF, 0, 0);

    reset = 1'b1; req_valid = 1'b0; req_op = '0;
    req_addr = '0; req_wdata = '0; req_pc = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wd", mem_wdata, 0);
    chk("rst_rd", rdata, 0);
    chk("rst_pc", exc_pc, 0);
    chk("rst_bva", exc_badvaddr, 0);
    chk("rst_flags", {exc_adel, exc_ades, bus_err}, 0);
    reset = 1'b0;

    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_ack_busy", busy, 0);
    chk("stray_ack_done", done, 0);

    for (int i = 0; i < 14; i++)
      do_vec($sformatf("v%0d", i), vt[i],
             32'h1000 + 32'(i) * 4);

    // No ack at all: four request cycles, then bus error.
    start(LSU_LW, 32'h200, 32'h0, 32'h2000);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tmo_req%0d", k), mem_req, 1);
      chk($sformatf("tmo_done%0d", k), done, 0);
      @(negedge clk);
    end
    chk("tmo_done", done, 1);
    chk("tmo_berr", bus_err, 1);
    chk("tmo_req_off", mem_req, 0);
    chk("tmo_rd", rdata, 0);
    chk("tmo_exc", {exc_adel, exc_ades}, 0);
    @(negedge clk);
    chk("tmo_idle", busy, 0);
    chk("tmo_berr_off", bus_err, 0);

    // Ack on the fourth wait cycle still completes normally.
    do_vec("ack4", mk(LSU_LW, 32'h204, 32'h0, 32'h55AA33CC, 3,
           32'h55AA33CC, 4'b1111, 32'h0, 0, 0), 32'h2004);

    start(LSU_LW, 32'h300, 32'h0, 32'h3000);
    chk("rstw_req", mem_req, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstw_busy", busy, 0);
    chk("rstw_req_off", mem_req, 0);
    chk("rstw_done", done, 0);
    for (int k = 0; k < 3; k++) begin
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      chk($sformatf("rstw_nodone%0d", k), done, 0);
    end
    do_vec("after_rst", mk(LSU_LW, 32'h304, 32'h0, 32'h01234567,
           0, 32'h01234567, 4'b1111, 32'h0, 0, 0), 32'h3004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store initiator between the MEM pipeline stage and a word-organised, byte-enabled data memory with a request/acknowledge handshake. It accepts one load or store per transaction from the pipeline and checks alignment. For stores it builds byte enables and replicated write data. For loads it extracts and sign- or zero-extends the addressed byte or halfword from the returned word. It is the requesting end of the data-memory port: the memory only stores words and byte lanes, and this block owns every sub-word decision.

## Interface
- TIMEOUT_CYCLES, default 255: maximum cycles in WAIT before the transaction is aborted with bus_err.
- clk  input  1  clock; every register updates on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- req_valid  input  1  pipeline requests a transaction; sampled only in IDLE.
- req_op  input  3  operation code (LSU_* in package).
- req_addr  input  32  byte address.
- req_wdata  input  32  store source register value.
- req_pc  input  32  PC of the instruction, carried to outputs.
- busy  output  1  high whenever the state is not IDLE; the pipeline stalls on it.
- done  output  1  one-cycle completion pulse.
- rdata  output  32  extended load result, valid when done is high and the op is a load.
- exc_adel / exc_ades  output  1  load or store address-error pulse, coincident with done.
- bus_err  output  1  timeout pulse, coincident with done.
- exc_pc, exc_badvaddr  output  32  captured req_pc and req_addr, valid with done.
- mem_req  output  1  memory request; held until acknowledged.
- mem_we  output  1  write transaction.
- mem_be  output  4  byte enables; bit i selects bits [8i+7:8i].
- mem_addr  output  32  word address, {req_addr[31:2], 2'b00}.
- mem_wdata  output  32  lane-replicated store data.
- mem_ack  input  1  memory completes the transaction this cycle.
- mem_rdata  input  32  read word; valid when mem_ack is high.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE, req_valid=1, address aligned: latch op, address, data and PC, then go to WAIT. Alignment rule: word ops need addr[1:0]=0; halfword ops need addr[0]=0; byte ops are always aligned.
- IDLE, req_valid=1, address misaligned: go to DONE with the matching exception flag set. No memory request is issued.
- WAIT: mem_req=1 with stable mem_we, mem_be, mem_addr and mem_wdata.
  - On mem_ack: capture mem_rdata and go to DONE.
  - If the timeout counter reaches TIMEOUT_CYCLES without mem_ack: drop mem_req, set bus_err, go to DONE.
- DONE: done=1 for one cycle, then return to IDLE. A new request is accepted no earlier than the following IDLE cycle.
- Store encoding (little-endian):
  - SW: be=1111, wdata=req_wdata.
  - SH: be=0011 if addr[1]=0, else 1100; wdata={2{req_wdata[15:0]}}.
  - SB: be=0001<<addr[1:0]; wdata={4{req_wdata[7:0]}}.
- Loads: be=1111, mem_we=0.
  - LB/LBU: select byte addr[1:0], then sign- or zero-extend to 32 bits.
  - LH/LHU: select halfword addr[1], then sign- or zero-extend to 32 bits.
  - LW: pass the word through.
- For stores, and on any exception or bus_err, rdata=0.

## Timing
- Reset values: state IDLE; busy, done, mem_req, mem_we, exc_adel, exc_ades and bus_err all 0; mem_be 0000; every 32-bit output 0; timeout counter 0.
- Latency:
  - Aligned access with zero-wait memory (mem_ack in the first WAIT cycle): accept edge, then WAIT for 1 cycle, then DONE for 1 cycle. busy is high for 2 cycles.
  - Each extra memory wait cycle adds exactly 1 cycle.
  - Misaligned access: busy and done are high together for 1 cycle.
- mem_ack outside WAIT is ignored.
- Timeout counter:
  - Cleared on entry to WAIT and increments each WAIT cycle without ack.
  - If mem_ack arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the ack wins and bus_err stays low.
- Reset asserted mid-transaction: return to IDLE on that edge and drop mem_req immediately. No done pulse is produced for the aborted access.
- All outputs are registered; nothing is combinational from the inputs to the mem_* signals.

## Structure
- Package lsu_pkg holds:
  - op codes LSU_LW=0, LSU_LH=1, LSU_LHU=2, LSU_LB=3, LSU_LBU=4, LSU_SW=5, LSU_SH=6, LSU_SB=7;
  - the state enum;
  - helper functions is_store, is_half, is_byte.
- One sub-module, lsu_load_align: a purely combinational word-to-result extractor/extender. The top holds the FSM, the timeout counter and the store encoding.

## Test plan
- SB, addr 0x00000013, wdata 0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x10. done arrives 2 cycles after acceptance with zero-wait ack.
- LB, addr 0x00000002, mem_rdata 0x12F03456 -> rdata=0xFFFFFFF0. Same access as LBU -> rdata=0x000000F0.
- LH, addr 0x00000006, mem_rdata 0x8001FFFF -> rdata=0xFFFF8001. LHU -> rdata=0x00008001.
- Misaligned accesses: LW at 0x00000102 -> exc_adel=1, exc_badvaddr=0x102, no mem_req. SH at 0x00000101 -> exc_ades=1.
- Memory never acks, TIMEOUT_CYCLES=4 -> mem_req held for exactly 4 cycles, then bus_err=1 with done. A separate run with ack on cycle 4 -> normal completion, bus_err=0.
- Reset asserted while in WAIT -> next cycle busy=0 and mem_req=0, no done pulse. The next LW completes normally.
